// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, select codes,
// ALU operations and the per-state Moore control word.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEXE = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_e;

    // How the ALU decoder should pick the operation in the current state.
    typedef enum logic [2:0] {
        ALU_NONE  = 3'd0,
        ALU_ADD   = 3'd1,
        ALU_SUB   = 3'd2,
        ALU_FUNCT = 3'd3,
        ALU_IMM   = 3'd4
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [3:0] ALUC_AND  = 4'b0000;
    localparam logic [3:0] ALUC_OR   = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0110;
    localparam logic [3:0] ALUC_SLT  = 4'b0111;
    localparam logic [3:0] ALUC_SLTU = 4'b1111;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       signext;
        logic       shiftl16;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] pcsrc;
        logic       pcen_uncond;
        aluop_e     aluop;
    } ctrl_t;

    function automatic logic funct_supported(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_SLT, FN_SLTU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Control word that depends only on the state (and the stable IR opcode).
    function automatic ctrl_t state_ctrl(input state_e st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        c.aluop = ALU_NONE;
        case (st)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.aluop   = ALU_ADD;
                c.pcsrc   = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                c.aluop   = ALU_ADD;
                c.signext = 1'b1;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.signext = 1'b1;
                c.aluop   = ALU_ADD;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.regdst   = REGDST_RT;
                c.memtoreg = M2R_MDR;
            end
            S_RTEXE: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = REGDST_RD;
                c.memtoreg = M2R_ALU;
            end
            S_IMMEXE: begin
                c.alusrca  = 1'b1;
                c.alusrcb  = SRCB_IMM;
                c.aluop    = ALU_IMM;
                c.signext  = !((op == OP_ORI) || (op == OP_LUI));
                c.shiftl16 = (op == OP_LUI);
            end
            S_IMMWB: begin
                c.regwrite = 1'b1;
                c.regdst   = REGDST_RT;
                c.memtoreg = M2R_ALU;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = ALU_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pcsrc       = PCSRC_JUMP;
                c.pcen_uncond = 1'b1;
            end
            S_JAL: begin
                c.pcsrc       = PCSRC_JUMP;
                c.pcen_uncond = 1'b1;
                c.regwrite    = 1'b1;
                c.regdst      = REGDST_RA;
                c.memtoreg    = M2R_PC;
            end
            S_JR: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_REG;
                c.aluop       = ALU_ADD;
                c.pcsrc       = PCSRC_ALU;
                c.pcen_uncond = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU operation decoder: turns the state's ALU request plus op/funct into alucontrol.
module mips_mc_aludec
    import mips_mc_pkg::*;
#(
    parameter int ALUCTL_W = 4
) (
    input  aluop_e              aluop_i,
    input  logic [5:0]          op_i,
    input  logic [5:0]          funct_i,
    output logic [ALUCTL_W-1:0] alucontrol_o
);

    logic [3:0] code;

    always_comb begin
        code = ALUC_AND;
        case (aluop_i)
            ALU_ADD: code = ALUC_ADD;
            ALU_SUB: code = ALUC_SUB;
            ALU_FUNCT: begin
                case (funct_i)
                    FN_ADD, FN_ADDU: code = ALUC_ADD;
                    FN_SUB, FN_SUBU: code = ALUC_SUB;
                    FN_AND:          code = ALUC_AND;
                    FN_OR:           code = ALUC_OR;
                    FN_SLT:          code = ALUC_SLT;
                    FN_SLTU:         code = ALUC_SLTU;
                    default:         code = ALUC_AND;
                endcase
            end
            ALU_IMM: begin
                // lui computes 0 + (imm << 16), so it shares the add path.
                case (op_i)
                    OP_ORI:   code = ALUC_OR;
                    OP_SLTI:  code = ALUC_SLT;
                    OP_SLTIU: code = ALUC_SLTU;
                    default:  code = ALUC_ADD;
                endcase
            end
            default: code = ALUC_AND;
        endcase
    end

    assign alucontrol_o = ALUCTL_W'(code);

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: sequences fetch, decode, execute, memory and write-back
// over a shared ALU and unified memory, with optional memory ready handshake.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ALUCTL_W      = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [5:0]          op_i,
    input  logic [5:0]          funct_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                memread_o,
    output logic                memwrite_o,
    output logic                iord_o,
    output logic                irwrite_o,
    output logic                pcen_o,
    output logic [1:0]          pcsrc_o,
    output logic                alusrca_o,
    output logic [1:0]          alusrcb_o,
    output logic                signext_o,
    output logic                shiftl16_o,
    output logic                regwrite_o,
    output logic [1:0]          regdst_o,
    output logic [1:0]          memtoreg_o,
    output logic [ALUCTL_W-1:0] alucontrol_o,
    output logic                illegal_o,
    output logic [3:0]          state_o
);

    state_e state_q, state_d;
    state_e dispatch;
    ctrl_t  ctrl_q;
    logic   mem_done;
    logic   decode_legal;
    logic   branch_taken;

    assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready_i;

    always_comb begin
        dispatch     = S_FETCH;
        decode_legal = 1'b1;
        case (op_i)
            OP_LW, OP_SW:   dispatch = S_MEMADR;
            OP_RTYPE: begin
                if (funct_i == FN_JR)
                    dispatch = S_JR;
                else if (funct_supported(funct_i))
                    dispatch = S_RTEXE;
                else
                    decode_legal = 1'b0;
            end
            OP_BEQ, OP_BNE: dispatch = S_BRANCH;
            OP_ADDI, OP_ADDIU, OP_ORI,
            OP_SLTI, OP_SLTIU, OP_LUI: dispatch = S_IMMEXE;
            OP_J:           dispatch = S_JUMP;
            OP_JAL:         dispatch = S_JAL;
            default:        decode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_done) state_d = S_DECODE;
            S_DECODE: state_d = dispatch;
            S_MEMADR: state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWR:  if (mem_done) state_d = S_FETCH;
            S_RTEXE:  state_d = S_ALUWB;
            S_IMMEXE: state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // The Moore control word is registered alongside the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH, op_i);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, op_i);
        end
    end

    mips_mc_aludec #(
        .ALUCTL_W (ALUCTL_W)
    ) u_aludec (
        .aluop_i      (ctrl_q.aluop),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .alucontrol_o (alucontrol_o)
    );

    assign branch_taken = zero_i ^ (op_i == OP_BNE);

    // Strobes and write enables are squashed while reset is held, abandoning any access.
    assign memread_o  = ctrl_q.memread  & ~reset_i;
    assign memwrite_o = ctrl_q.memwrite & ~reset_i;
    assign regwrite_o = ctrl_q.regwrite & ~reset_i;
    assign irwrite_o  = ~reset_i & (state_q == S_FETCH) & mem_done;
    assign pcen_o     = ~reset_i & (((state_q == S_FETCH) & mem_done) |
                                    ((state_q == S_BRANCH) & branch_taken) |
                                    ctrl_q.pcen_uncond);
    assign illegal_o  = ~reset_i & (state_q == S_DECODE) & ~decode_legal;

    assign iord_o     = ctrl_q.iord;
    assign pcsrc_o    = ctrl_q.pcsrc;
    assign alusrca_o  = ctrl_q.alusrca;
    assign alusrcb_o  = ctrl_q.alusrcb;
    assign signext_o  = ctrl_q.signext;
    assign shiftl16_o = ctrl_q.shiftl16;
    assign regdst_o   = ctrl_q.regdst;
    assign memtoreg_o = ctrl_q.memtoreg;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: table of instructions with expected state
// sequences, a per-state output model, and hand sequences for waits and reset.
module tb_mips_mc_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       signext;
        logic       shiftl16;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [3:0] alucontrol;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic [63:0] name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [2:0]  n;
        logic [19:0] seq;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;

    logic [3:0] st_a, alc_a, st_b, alc_b;
    logic       mr_a, mw_a, iord_a, irw_a, pcen_a, asa_a, sx_a, sh_a, rw_a, ill_a;
    logic       mr_b, mw_b, iord_b, irw_b, pcen_b, asa_b, sx_b, sh_b, rw_b, ill_b;
    logic [1:0] pcs_a, asb_a, rd_a, m2r_a, pcs_b, asb_b, rd_b, m2r_b;
    out_t       act_a, act_b;

    int total = 0;
    int bad   = 0;
    out_t sb_q[$];
    vec_t vecs[25];

    always #5 clk = ~clk;

    mips_mc_controller #(.MEM_HANDSHAKE(1), .ALUCTL_W(4)) dut_a (
        .clk_i(clk), .reset_i(reset), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .memread_o(mr_a), .memwrite_o(mw_a), .iord_o(iord_a),
        .irwrite_o(irw_a), .pcen_o(pcen_a), .pcsrc_o(pcs_a), .alusrca_o(asa_a),
        .alusrcb_o(asb_a), .signext_o(sx_a), .shiftl16_o(sh_a), .regwrite_o(rw_a),
        .regdst_o(rd_a), .memtoreg_o(m2r_a), .alucontrol_o(alc_a), .illegal_o(ill_a),
        .state_o(st_a));

    mips_mc_controller #(.MEM_HANDSHAKE(0), .ALUCTL_W(4)) dut_b (
        .clk_i(clk), .reset_i(reset), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .memread_o(mr_b), .memwrite_o(mw_b), .iord_o(iord_b),
        .irwrite_o(irw_b), .pcen_o(pcen_b), .pcsrc_o(pcs_b), .alusrca_o(asa_b),
        .alusrcb_o(asb_b), .signext_o(sx_b), .shiftl16_o(sh_b), .regwrite_o(rw_b),
        .regdst_o(rd_b), .memtoreg_o(m2r_b), .alucontrol_o(alc_b), .illegal_o(ill_b),
        .state_o(st_b));

    assign act_a = {st_a, mr_a, mw_a, iord_a, irw_a, pcen_a, pcs_a, asa_a, asb_a,
                    sx_a, sh_a, rw_a, rd_a, m2r_a, alc_a, ill_a};
    assign act_b = {st_b, mr_b, mw_b, iord_b, irw_b, pcen_b, pcs_b, asa_b, asb_b,
                    sx_b, sh_b, rw_b, rd_b, m2r_b, alc_b, ill_b};

    function automatic logic legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b001001,
            6'b001101, 6'b001010, 6'b001011, 6'b001111, 6'b000010, 6'b000011: return 1'b1;
            6'b000000: begin
                case (f)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                    6'b100101, 6'b101010, 6'b101011, 6'b001000: return 1'b1;
                    default: return 1'b0;
                endcase
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] rt_alu(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001: return 4'b0010;
            6'b100010, 6'b100011: return 4'b0110;
            6'b100101:            return 4'b0001;
            6'b101010:            return 4'b0111;
            6'b101011:            return 4'b1111;
            default:              return 4'b0000;
        endcase
    endfunction

    // Expected outputs for a given state and current-cycle inputs.
    function automatic out_t model(input logic [3:0] st, input logic [5:0] o,
                                   input logic [5:0] f, input logic z, input logic rdy,
                                   input logic rst, input logic hs);
        out_t e;
        logic done;
        e = '0;
        done = !hs || rdy;
        e.state = st;
        case (st)
            4'd0: begin e.memread = 1; e.alusrcb = 2'b01; e.alucontrol = 4'b0010;
                        e.irwrite = done; e.pcen = done; end
            4'd1: begin e.alusrcb = 2'b11; e.alucontrol = 4'b0010; e.signext = 1;
                        e.illegal = !legal(o, f); end
            4'd2: begin e.alusrca = 1; e.alusrcb = 2'b10; e.signext = 1;
                        e.alucontrol = 4'b0010; end
            4'd3: begin e.memread = 1; e.iord = 1; end
            4'd4: begin e.regwrite = 1; e.memtoreg = 2'b01; end
            4'd5: begin e.memwrite = 1; e.iord = 1; end
            4'd6: begin e.alusrca = 1; e.alucontrol = rt_alu(f); end
            4'd7: begin e.regwrite = 1; e.regdst = 2'b01; end
            4'd8: begin e.alusrca = 1; e.alucontrol = 4'b0110; e.pcsrc = 2'b01;
                        e.pcen = z ^ (o == 6'b000101); end
            4'd9: begin
                e.alusrca = 1; e.alusrcb = 2'b10;
                case (o)
                    6'b001101: e.alucontrol = 4'b0001;
                    6'b001111: begin e.alucontrol = 4'b0010; e.shiftl16 = 1; end
                    6'b001010: begin e.alucontrol = 4'b0111; e.signext = 1; end
                    6'b001011: begin e.alucontrol = 4'b1111; e.signext = 1; end
                    default:   begin e.alucontrol = 4'b0010; e.signext = 1; end
                endcase
            end
            4'd10: e.regwrite = 1;
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1; end
            4'd12: begin e.pcsrc = 2'b10; e.pcen = 1; e.regwrite = 1; e.regdst = 2'b10;
                         e.memtoreg = 2'b10; end
            4'd13: begin e.alusrca = 1; e.alucontrol = 4'b0010; e.pcen = 1; end
            default: ;
        endcase
        if (rst) begin
            e.pcen = 0; e.irwrite = 0; e.regwrite = 0;
            e.memread = 0; e.memwrite = 0; e.illegal = 0;
        end
        return e;
    endfunction

    // One clock: drive, queue the expectation, compare mid-cycle, advance past the edge.
    task automatic step(input logic [3:0] st, input logic rdy, input logic rst,
                        input logic hs, input logic [63:0] nm);
        out_t exp_o, act_o;
        mem_ready = rdy;
        reset     = rst;
        sb_q.push_back(model(st, op, funct, zero, rdy, rst, hs));
        @(negedge clk);
        exp_o = sb_q.pop_front();
        act_o = hs ? act_a : act_b;
        total++;
        if (act_o !== exp_o) begin
            bad++;
            $display("FAIL %0s: state got %0d want %0d, outputs got %h want %h",
                     nm, act_o.state, exp_o.state, act_o, exp_o);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{"lw",    6'b100011, 6'b000000, 1'b0, 3'd5, 20'h43210};
        vecs[1]  = '{"sw",    6'b101011, 6'b000000, 1'b0, 3'd4, 20'h05210};
        vecs[2]  = '{"add",   6'b000000, 6'b100000, 1'b0, 3'd4, 20'h07610};
        vecs[3]  = '{"addu",  6'b000000, 6'b100001, 1'b0, 3'd4, 20'h07610};
        vecs[4]  = '{"sub",   6'b000000, 6'b100010, 1'b0, 3'd4, 20'h07610};
        vecs[5]  = '{"and",   6'b000000, 6'b100100, 1'b0, 3'd4, 20'h07610};
        vecs[6]  = '{"or",    6'b000000, 6'b100101, 1'b0, 3'd4, 20'h07610};
        vecs[7]  = '{"slt",   6'b000000, 6'b101010, 1'b0, 3'd4, 20'h07610};
        vecs[8]  = '{"sltu",  6'b000000, 6'b101011, 1'b0, 3'd4, 20'h07610};
        vecs[9]  = '{"addi",  6'b001000, 6'b000000, 1'b0, 3'd4, 20'h0A910};
        vecs[10] = '{"addiu", 6'b001001, 6'b000000, 1'b0, 3'd4, 20'h0A910};
        vecs[11] = '{"ori",   6'b001101, 6'b000000, 1'b0, 3'd4, 20'h0A910};
        vecs[12] = '{"slti",  6'b001010, 6'b000000, 1'b0, 3'd4, 20'h0A910};
        vecs[13] = '{"sltiu", 6'b001011, 6'b000000, 1'b0, 3'd4, 20'h0A910};
        vecs[14] = '{"lui",   6'b001111, 6'b000000, 1'b0, 3'd4, 20'h0A910};
        vecs[15] = '{"beq_z1", 6'b000100, 6'b000000, 1'b1, 3'd3, 20'h00810};
        vecs[16] = '{"beq_z0", 6'b000100, 6'b000000, 1'b0, 3'd3, 20'h00810};
        vecs[17] = '{"bne_z0", 6'b000101, 6'b000000, 1'b0, 3'd3, 20'h00810};
        vecs[18] = '{"bne_z1", 6'b000101, 6'b000000, 1'b1, 3'd3, 20'h00810};
        vecs[19] = '{"j",     6'b000010, 6'b000000, 1'b0, 3'd3, 20'h00B10};
        vecs[20] = '{"jal",   6'b000011, 6'b000000, 1'b0, 3'd3, 20'h00C10};
        vecs[21] = '{"jr",    6'b000000, 6'b001000, 1'b0, 3'd3, 20'h00D10};
        vecs[22] = '{"ill_op", 6'b111111, 6'b000000, 1'b0, 3'd2, 20'h00010};
        vecs[23] = '{"ill_fn", 6'b000000, 6'b000000, 1'b0, 3'd2, 20'h00010};
        vecs[24] = '{"ill_op2", 6'b110000, 6'b100000, 1'b0, 3'd2, 20'h00010};

        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(4'd0, 1'b1, 1'b1, 1'b1, "rst_a");
        step(4'd0, 1'b1, 1'b1, 1'b0, "rst_b");

        for (int v = 0; v < 25; v++) begin
            op    = vecs[v].op;
            funct = vecs[v].funct;
            zero  = vecs[v].zero;
            for (int i = 0; i < int'(vecs[v].n); i++)
                step(vecs[v].seq[4*i +: 4], 1'b1, 1'b0, 1'b1, vecs[v].name);
        end

        // Fetch wait, then sw with three wait cycles in MEMWR.
        op = 6'b101011; funct = 6'd0; zero = 1'b0;
        step(4'd0, 1'b0, 1'b0, 1'b1, "fwait");
        step(4'd0, 1'b0, 1'b0, 1'b1, "fwait");
        step(4'd0, 1'b1, 1'b0, 1'b1, "sw_wait");
        step(4'd1, 1'b1, 1'b0, 1'b1, "sw_wait");
        step(4'd2, 1'b1, 1'b0, 1'b1, "sw_wait");
        for (int i = 0; i < 3; i++)
            step(4'd5, 1'b0, 1'b0, 1'b1, "sw_wait");
        step(4'd5, 1'b1, 1'b0, 1'b1, "sw_wait");

        // lw abandoned by reset during the MEMRD wait, then a clean lw.
        op = 6'b100011;
        step(4'd0, 1'b1, 1'b0, 1'b1, "lw_rst");
        step(4'd1, 1'b1, 1'b0, 1'b1, "lw_rst");
        step(4'd2, 1'b1, 1'b0, 1'b1, "lw_rst");
        step(4'd3, 1'b0, 1'b0, 1'b1, "lw_rst");
        step(4'd3, 1'b0, 1'b1, 1'b1, "lw_rst");
        step(4'd0, 1'b1, 1'b0, 1'b1, "lw_after");
        step(4'd1, 1'b1, 1'b0, 1'b1, "lw_after");
        step(4'd2, 1'b1, 1'b0, 1'b1, "lw_after");
        step(4'd3, 1'b0, 1'b0, 1'b1, "lw_after");
        step(4'd3, 1'b1, 1'b0, 1'b1, "lw_after");
        step(4'd4, 1'b1, 1'b0, 1'b1, "lw_after");
        step(4'd0, 1'b1, 1'b0, 1'b1, "lw_after");

        // No-handshake build: lw still 5 cycles with mem_ready held low.
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(4'd0, 1'b0, 1'b1, 1'b0, "nohs_rst");
        for (int i = 0; i < 6; i++)
            step((i == 5) ? 4'd0 : 4'(i), 1'b0, 1'b0, 1'b0, "nohs_lw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multi-cycle control unit for the next-generation MIPS core. It replaces single-cycle decode with a state machine that sequences one instruction over 3–5 cycles through a shared ALU and a unified instruction/data memory. It adds a variable-latency memory handshake, enabled by a parameter. It sits between the instruction register/datapath and the memory port, and drives every datapath enable and mux select.

## Interface
- `MEM_HANDSHAKE`, default 1. 1: each memory state waits for `mem_ready`. 0: each memory access completes in one cycle and `mem_ready` is ignored.
- `ALUCTL_W`, default 4. Width of `alucontrol`; must be ≥ 4.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; the controller has no other clock or reset.
- `op`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0] from the instruction register.
- `zero`  in  1  ALU zero flag, current cycle.
- `mem_ready`  in  1  memory has accepted the write or returned read data this cycle.
- `memread`, `memwrite`  out  1  memory strobes.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  load instruction register.
- `pcen`  out  1  PC load enable, including the resolved branch condition.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 00}.
- `alusrca`  out  1  ALU A: 0 = PC, 1 = A register.
- `alusrcb`  out  2  ALU B: 00 = B register, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2.
- `signext`, `shiftl16`  out  1  immediate extension controls.
- `regwrite`  out  1  register file write enable.
- `regdst`  out  2  write register: 00 = rt, 01 = rd, 10 = $31.
- `memtoreg`  out  2  write data: 00 = ALUOut, 01 = memory data register, 10 = PC.
- `alucontrol`  out  `ALUCTL_W`  ALU operation: add 0010, sub 0110, and 0000, or 0001, slt 0111, sltu 1111.
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported op or funct.
- `state`  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, ALUWB 7, BRANCH 8, IMMEXE 9, IMMWB 10, JUMP 11, JAL 12, JR 13.
- FETCH:
  - Drive `memread`, `iord`=0, `alusrca`=0, `alusrcb`=01, add, `pcsrc`=00.
  - On the completing cycle, assert `irwrite` and `pcen`, then go to DECODE.
- DECODE:
  - Drive `alusrca`=0, `alusrcb`=11, add, `signext`=1. This precomputes the branch target.
  - Dispatch by instruction:
    - lw / sw → MEMADR
    - R-type (except jr) → RTEXE
    - funct 001000 (jr) → JR
    - beq / bne → BRANCH
    - addi / addiu / ori / slti / sltiu / lui → IMMEXE
    - j → JUMP
    - jal → JAL
    - anything else → `illegal`=1, then FETCH
- MEMADR: A + sign-extended immediate. lw → MEMRD; sw → MEMWR.
- MEMRD: `memread`, `iord`=1; on completion → MEMWB.
- MEMWR: `memwrite`, `iord`=1; on completion → FETCH.
- MEMWB: `regwrite`, `regdst`=00, `memtoreg`=01, then FETCH.
- RTEXE: `alusrca`=1, `alusrcb`=00, `alucontrol` from funct; then ALUWB.
- ALUWB: `regwrite`, `regdst`=01, `memtoreg`=00, then FETCH.
- IMMEXE:
  - Drive `alusrca`=1, `alusrcb`=10.
  - Per instruction: addi/addiu add with `signext`=1; ori or with `signext`=0; slti slt and sltiu sltu, both with `signext`=1; lui add with `shiftl16`=1 and `signext`=0 (result is 0 + imm<<16).
  - Then IMMWB.
- IMMWB: `regwrite`, `regdst`=00, `memtoreg`=00, then FETCH.
- BRANCH:
  - Drive `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01.
  - `pcen` = `zero` XOR (op == bne).
  - Then FETCH.
- JUMP: `pcsrc`=10, `pcen`=1, then FETCH.
- JAL: `pcsrc`=10, `pcen`=1, `regwrite`, `regdst`=10, `memtoreg`=10 (PC already holds PC+4), then FETCH.
- JR: `alusrca`=1, `alusrcb`=00, add (rs + $0), `pcsrc`=00, `pcen`=1, no `regwrite`, then FETCH.
- Completion rule:
  - `MEM_HANDSHAKE`=1: a memory state completes in the cycle `mem_ready`=1. Until then it holds with strobes asserted and `irwrite`/`pcen`/`regwrite` at 0.
  - `MEM_HANDSHAKE`=0: every memory state completes in its first cycle.
- Default for every output not listed in a state: 0.

## Timing
- Outputs are Moore-style from `state`, except three outputs that also depend on inputs in the current cycle:
  - `pcen` in BRANCH (depends on `zero`).
  - FETCH `irwrite`/`pcen` (depend on `mem_ready`).
  - `illegal` (depends on `op`/`funct`).
- Cycles per instruction with zero wait: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, jal 3, jr 3. Each wait cycle of `mem_ready` adds 1.
- Reset:
  - `state` = FETCH on the edge where `reset`=1.
  - While `reset`=1, these outputs are forced to 0 combinationally: `pcen`, `irwrite`, `regwrite`, `memread`, `memwrite`, `illegal`.
  - A reset during a memory wait abandons the access; there is no partial write-back.
- `mem_ready` asserted outside a memory state is ignored.

## Structure
- Package `mips_mc_pkg` holds:
  - state encodings
  - op/funct constants
  - `alusrcb`, `pcsrc`, `regdst` and `memtoreg` select constants
  - ALU operation codes
- One sub-module: `mips_mc_aludec` (funct → `alucontrol`, combinational). The FSM and output decode stay in the top module.

## Test plan
- `MEM_HANDSHAKE`=1, `mem_ready` tied to 1, lw → states 0,1,2,3,4; `regwrite`=1 with `memtoreg`=01 only in state 4; 5 cycles total.
- sw with `mem_ready` low for 3 cycles in MEMWR → `memwrite` held for 4 cycles; FETCH follows exactly one cycle after `mem_ready`=1.
- bne with `zero`=0 → `pcen`=1 in BRANCH with `pcsrc`=01. beq with `zero`=0 → `pcen`=0.
- jal → in JAL: `regdst`=10, `memtoreg`=10, `regwrite`=1, `pcsrc`=10. jr (funct 001000) → `regwrite` is never asserted.
- op 111111 → `illegal` pulses once in DECODE; next state is FETCH; no write enables are asserted.
- `reset` asserted in MEMRD during a wait → next `state`=0; `memread`=0 during the reset cycle. `MEM_HANDSHAKE`=0 with `mem_ready`=0 → lw still takes 5 cycles.
